vga_ball_mover: RTL and testbench

// - Avalon-MM write initiator that drives the ball peripheral's register port
//   (chipselect/write/address/writedata) from fabric instead of from the HPS.
// - Once per N frames, at vertical sync, steps the ball cell position (x,y) by
//   +/-1 per axis, bouncing at the edges.
// - Then issues posted writes: X to address 1, Y to address 2.
// - Sits beside the ball peripheral.
// - Its VGA_VS output feeds vsync_n here; its register inputs are fed from here.

---
 rtl/vga_ball_pkg.sv | 31 +++
 rtl/ball_axis.sv | 39 +++
 rtl/vga_ball_mover.sv | 142 ++++++++++++++
 tb/tb_vga_ball_mover.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_ball_pkg.sv
// Shared register map, FSM encoding and cell type for the fabric-side ball mover.
// Optional background-flash write is enabled with `define BOUNCE_FLASH_EN.
package vga_ball_pkg;

  localparam logic [2:0] REG_BG_R = 3'h0;
  localparam logic [2:0] REG_X    = 3'h1;
  localparam logic [2:0] REG_Y    = 3'h2;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    WR_X,
    WR_Y,
    WR_R
  } mover_state_t;

  typedef logic [5:0] cell_t;

  typedef struct packed {
    mover_state_t state;
    logic         x_bounced;
    logic         y_bounced;
    logic [7:0]   frame_cnt;
  } mover_dbg_t;

  // Register byte layout for a cell coordinate.
  function automatic logic [7:0] coord_byte(input cell_t c);
    return {2'b00, c};
  endfunction

endpackage

// File: rtl/ball_axis.sv
// One ball coordinate plus its direction; moves one cell per step pulse and
// reflects off 0 and MAX. bounced reports whether the latest step reflected.
module ball_axis
  import vga_ball_pkg::*;
#(
  parameter cell_t MAX  = 6'd39,
  parameter cell_t INIT = 6'd0
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  step,
  output cell_t pos,
  output logic  bounced
);

  logic dir_up;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos     <= INIT;
      dir_up  <= 1'b1;
      bounced <= 1'b0;
    end else if (step) begin
      if (dir_up && pos == MAX) begin
        pos     <= MAX - 6'd1;
        dir_up  <= 1'b0;
        bounced <= 1'b1;
      end else if (!dir_up && pos == 6'd0) begin
        pos     <= 6'd1;
        dir_up  <= 1'b1;
        bounced <= 1'b1;
      end else begin
        pos     <= dir_up ? pos + 6'd1 : pos - 6'd1;
        bounced <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vga_ball_mover.sv
// Fabric Avalon-MM write initiator that steps the ball once per N frames and
// posts X/Y register writes. `define BOUNCE_FLASH_EN adds a background-red write.
module vga_ball_mover
  import vga_ball_pkg::*;
#(
  parameter int         X_MAX           = 39,
  parameter int         Y_MAX           = 29,
  parameter int         X_INIT          = 0,
  parameter int         Y_INIT          = 0,
  parameter int         FRAMES_PER_STEP = 1,
  parameter logic [7:0] BASE_R          = 8'h00,
  parameter logic [7:0] FLASH_R         = 8'hff
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       vsync_n,
  input  logic       waitrequest,
  output logic       chipselect,
  output logic       write,
  output logic [2:0] address,
  output logic [7:0] writedata,
  output logic       busy,
  output mover_dbg_t dbg
);

  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_STEP - 1);

  mover_state_t state;
  logic [7:0]   frame_cnt;
  logic         vs_q;
  logic         tick;
  cell_t        x_pos;
  cell_t        y_pos;
  logic         x_bounced;
  logic         y_bounced;
  logic [7:0]   bg_q;

  assign tick = vs_q & ~vsync_n;

  ball_axis #(.MAX(cell_t'(X_MAX)), .INIT(cell_t'(X_INIT))) u_x (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (state == STEP),
    .pos     (x_pos),
    .bounced (x_bounced)
  );

  ball_axis #(.MAX(cell_t'(Y_MAX)), .INIT(cell_t'(Y_INIT))) u_y (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (state == STEP),
    .pos     (y_pos),
    .bounced (y_bounced)
  );

  // chipselect/write form the valid; waitrequest low is the ready. A write is
  // taken on every edge where valid is high and waitrequest is low, and
  // address/writedata stay constant from the first valid cycle until then.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      chipselect <= 1'b0;
      write      <= 1'b0;
      address    <= REG_BG_R;
      frame_cnt  <= '0;
      vs_q       <= 1'b1;
      bg_q       <= 8'h00;
    end else begin
      vs_q <= vsync_n;
      case (state)
        IDLE: begin
          if (tick && enable) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              state     <= STEP;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        STEP: begin
          state      <= WR_X;
          chipselect <= 1'b1;
          write      <= 1'b1;
          address    <= REG_X;
        end
        WR_X: begin
          if (!waitrequest) begin
            state   <= WR_Y;
            address <= REG_Y;
          end
        end
        WR_Y: begin
          if (!waitrequest) begin
`ifdef BOUNCE_FLASH_EN
            state   <= WR_R;
            address <= REG_BG_R;
            bg_q    <= (x_bounced || y_bounced) ? FLASH_R : BASE_R;
`else
            state      <= IDLE;
            chipselect <= 1'b0;
            write      <= 1'b0;
`endif
          end
        end
        WR_R: begin
          if (!waitrequest) begin
            state      <= IDLE;
            chipselect <= 1'b0;
            write      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data follows the held address, so it only changes together with it and
  // the positions themselves move only at the STEP edge.
  always_comb begin
    writedata = bg_q;
    case (address)
      REG_X:   writedata = coord_byte(x_pos);
      REG_Y:   writedata = coord_byte(y_pos);
      default: writedata = bg_q;
    endcase
  end

`ifndef BOUNCE_FLASH_EN
  // Background colours only matter in the flash build.
  if (BASE_R == FLASH_R) begin : g_flash_colours_equal
  end
`endif

  assign busy          = (state != IDLE);
  assign dbg.state     = state;
  assign dbg.x_bounced = x_bounced;
  assign dbg.y_bounced = y_bounced;
  assign dbg.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_vga_ball_mover.sv
// Bench for vga_ball_mover: three instances (default, X_INIT=38, three frames
// per step) scored against a reflection model of ball position per step count.
module tb_vga_ball_mover;
  import vga_ball_pkg::*;

  localparam int XM = 39;
  localparam int YM = 29;
`ifdef BOUNCE_FLASH_EN
  localparam int WPS = 3;
`else
  localparam int WPS = 2;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic vsync_n = 1'b1;
  logic waitrequest = 1'b0;

  logic       cs   [3];
  logic       wr   [3];
  logic [2:0] addr [3];
  logic [7:0] wd   [3];
  logic       bsy  [3];
  mover_dbg_t dbg  [3];

  always #10 clk = ~clk;

  vga_ball_mover u0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .vsync_n(vsync_n),
    .waitrequest(waitrequest), .chipselect(cs[0]), .write(wr[0]),
    .address(addr[0]), .writedata(wd[0]), .busy(bsy[0]), .dbg(dbg[0])
  );
  vga_ball_mover #(.X_INIT(38)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .vsync_n(vsync_n),
    .waitrequest(waitrequest), .chipselect(cs[1]), .write(wr[1]),
    .address(addr[1]), .writedata(wd[1]), .busy(bsy[1]), .dbg(dbg[1])
  );
  vga_ball_mover #(.FRAMES_PER_STEP(3)) u2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .vsync_n(vsync_n),
    .waitrequest(waitrequest), .chipselect(cs[2]), .write(wr[2]),
    .address(addr[2]), .writedata(wd[2]), .busy(bsy[2]), .dbg(dbg[2])
  );

  int tests = 0;
  int fails = 0;

  logic [10:0] exp_q [3][$];
  logic [7:0]  obs_x [3][$];
  logic [7:0]  obs_r [3][$];
  int wr_cnt [3] = '{0, 0, 0};
  int nsteps [3] = '{0, 0, 0};
  int fcnt   [3] = '{0, 0, 0};
  int xinit  [3] = '{0, 38, 0};
  int fps    [3] = '{1, 1, 3};
  bit rand_mode = 1'b0;
  int wr_streak = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Position after n steps from init heading up: a triangle wave of period 2*max.
  function automatic int tri_pos(input int init, input int n, input int mx);
    int t;
    t = (init + n) % (2 * mx);
    return (t <= mx) ? t : 2 * mx - t;
  endfunction

  // Step n reflects when it starts from an end cell, except the very first
  // step out of cell 0 which is already heading up.
  function automatic bit reflects(input int init, input int n, input int mx);
    int tp;
    tp = (init + n - 1) % (2 * mx);
    return (tp == mx) || (tp == 0 && n > 1);
  endfunction

  task automatic model_tick(input int i);
    int n;
    if (fcnt[i] == fps[i] - 1) begin
      fcnt[i] = 0;
      nsteps[i]++;
      n = nsteps[i];
      exp_q[i].push_back({REG_X, 8'(tri_pos(xinit[i], n, XM))});
      exp_q[i].push_back({REG_Y, 8'(tri_pos(0, n, YM))});
`ifdef BOUNCE_FLASH_EN
      exp_q[i].push_back({REG_BG_R,
        (reflects(xinit[i], n, XM) || reflects(0, n, YM)) ? 8'hff : 8'h00});
`endif
    end else begin
      fcnt[i]++;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      obs_x[i].delete();
      obs_r[i].delete();
      nsteps[i] = 0;
      fcnt[i] = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      enable = ($urandom_range(0, 5) != 0);
      if (wr_streak < 3 && $urandom_range(0, 3) == 0) begin
        waitrequest = 1'b1;
        wr_streak++;
      end else begin
        waitrequest = 1'b0;
        wr_streak = 0;
      end
    end
  endtask

  task automatic gap(input int n);
    repeat (n) cyc();
  endtask

  // One-cycle low pulse on vsync_n; an instance counts it only when it is idle.
  task automatic vs_fall();
    bit counted [3];
    vsync_n = 1'b0;
    for (int i = 0; i < 3; i++) counted[i] = enable && (exp_q[i].size() == 0);
    cyc();
    vsync_n = 1'b1;
    for (int i = 0; i < 3; i++) if (counted[i]) model_tick(i);
  endtask

  // Scoreboard: busy tracks outstanding expectations; each accepted write pops one.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("busy_u%0d", i), 32'(bsy[i]), 32'(exp_q[i].size() != 0));
        if (cs[i] && wr[i] && !waitrequest) begin
          logic [10:0] e;
          wr_cnt[i]++;
          if (addr[i] == REG_X) obs_x[i].push_back(wd[i]);
          if (addr[i] == REG_BG_R) obs_r[i].push_back(wd[i]);
          if (exp_q[i].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write_u%0d: got addr %0h data %0h expected none",
                     i, addr[i], wd[i]);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("write_u%0d", i), {21'd0, addr[i], wd[i]}, {21'd0, e});
          end
        end
      end
    end
  end

  logic       s_cs   [7];
  logic [2:0] s_addr [7];
  logic [7:0] s_wd   [7];
  logic       s_bsy  [7];

  initial begin
    int c0, csum;
    int base [3];

    // Reset values, sampled while reset is held.
    reset_n = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    check("rst_cs", 32'(cs[0]), 0);
    check("rst_write", 32'(wr[0]), 0);
    check("rst_addr", 32'(addr[0]), 0);
    check("rst_wdata", 32'(wd[0]), 0);
    check("rst_busy", 32'(bsy[0]), 0);
    check("rst_state", 32'(dbg[0].state), 32'(IDLE));
    cyc();
    reset_n = 1'b1;
    gap(3);

    // First step: exact cycle-by-cycle shape.
    vs_fall();
    check("model_first_x", 32'(exp_q[0][0]), {21'd0, REG_X, 8'h01});
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      s_cs[k] = cs[0]; s_addr[k] = addr[0]; s_wd[k] = wd[0]; s_bsy[k] = bsy[0];
    end
    check("lat_step_busy", 32'(s_bsy[1]), 1);
    check("lat_step_cs", 32'(s_cs[1]), 0);
    check("lat_wrx", {s_cs[2], 21'd0, s_addr[2], s_wd[2]}, {1'b1, 21'd0, REG_X, 8'h01});
    check("lat_wry", {s_cs[3], 21'd0, s_addr[3], s_wd[3]}, {1'b1, 21'd0, REG_Y, 8'h01});
`ifdef BOUNCE_FLASH_EN
    check("lat_wrr", {s_cs[4], 21'd0, s_addr[4], s_wd[4]}, {1'b1, 21'd0, REG_BG_R, 8'h00});
    check("lat_idle_busy", 32'(s_bsy[5]), 0);
`else
    check("lat_idle_hold", {s_cs[4], 21'd0, s_addr[4], s_wd[4]}, {1'b0, 21'd0, REG_Y, 8'h01});
    check("lat_idle_busy", 32'(s_bsy[4]), 0);
`endif
    csum = 0;
    for (int k = 1; k < 7; k++) csum += int'(s_cs[k]);
    check("strobe_cycles", csum, WPS);
    gap(8);

    // X_INIT=38 instance bounces off X_MAX on its second step.
    vs_fall();
    gap(10);
    vs_fall();
    gap(10);
    check("bounce_nx", obs_x[1].size(), 3);
    if (obs_x[1].size() == 3) begin
      check("bounce_x1", 32'(obs_x[1][0]), 32'h27);
      check("bounce_x2", 32'(obs_x[1][1]), 32'h26);
      check("bounce_x3", 32'(obs_x[1][2]), 32'h25);
    end
`ifdef BOUNCE_FLASH_EN
    check("flash_nr", obs_r[1].size(), 3);
    if (obs_r[1].size() == 3) begin
      check("flash_r1", 32'(obs_r[1][0]), 32'h00);
      check("flash_r2", 32'(obs_r[1][1]), 32'hff);
      check("flash_r3", 32'(obs_r[1][2]), 32'h00);
    end
`endif

    // Four stalled WR_X cycles: request held steady for five cycles.
    vs_fall();
    waitrequest = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("stall_hold_%0d", j), {cs[0], wr[0], 19'd0, addr[0], wd[0]},
            {1'b1, 1'b1, 19'd0, REG_X, 8'h04});
      if (j == 3) begin
        @(posedge clk);
        #1;
        waitrequest = 1'b0;
      end
    end
    gap(10);

    // A falling edge while busy is dropped.
    c0 = wr_cnt[0];
    vs_fall();
    cyc();
    vs_fall();
    gap(12);
    check("busy_edge_dropped", wr_cnt[0] - c0, WPS);

    // Three frames per step: six edges make exactly two steps.
    model_clear();
    reset_n = 1'b0;
    gap(2);
    reset_n = 1'b1;
    gap(2);
    c0 = wr_cnt[2];
    repeat (6) begin
      vs_fall();
      gap(8);
    end
    check("fps3_writes", wr_cnt[2] - c0, 2 * WPS);

    // Ticks ignored while disabled.
    for (int i = 0; i < 3; i++) base[i] = wr_cnt[i];
    enable = 1'b0;
    repeat (5) begin
      vs_fall();
      gap(8);
    end
    enable = 1'b1;
    check("disabled_writes", (wr_cnt[0] - base[0]) + (wr_cnt[1] - base[1]) + (wr_cnt[2] - base[2]), 0);

    // Reset in the middle of a stalled X write.
    vs_fall();
    waitrequest = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_cs", {cs[0], 21'd0, addr[0]}, {1'b1, 21'd0, REG_X});
    cyc();
    reset_n = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("abort_strobes", {30'd0, cs[0], wr[0]}, 0);
    waitrequest = 1'b0;
    cyc();
    reset_n = 1'b1;
    gap(2);
    vs_fall();
    gap(10);
    check("post_rst_nx", 32'(obs_x[0].size() != 0), 1);
    if (obs_x[0].size() != 0) check("post_rst_x", 32'(obs_x[0][0]), 32'h01);

    // Random frames, enable and stalls against the model.
    rand_mode = 1'b1;
    repeat (110) begin
      vs_fall();
      gap($urandom_range(20, 30));
    end
    rand_mode = 1'b0;
    enable = 1'b1;
    waitrequest = 1'b0;
    gap(30);
    for (int i = 0; i < 3; i++) check($sformatf("drain_u%0d", i), exp_q[i].size(), 0);
    check("random_steps_u0", 32'(nsteps[0] > XM), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
